// File: rtl/tile_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tile_update_ctrl
// Purpose  : Runtime-writable 20x15 tile colour map for the VGA path.
//            Parses a UART byte stream into tile writes. Each write is held in
//            a one-entry pending slot and lands in the tile store only while
//            video is blanked. The store serves the 12-bit colour for the
//            current pixel on a 32x32-pixel tile grid.
// Options  : TILE_CLEAR_EN - adds a fill-all packet (HDR_CLR, HI, LO) and a
//            blanking-time sweep that writes every tile.
// Revision : 1.0 - initial release
// ============================================================================
module tile_update_ctrl #(
  parameter int         TILES_X = 20,
  parameter int         TILES_Y = 15,
  parameter logic [7:0] HDR_WR  = 8'hA5,
  parameter logic [7:0] HDR_CLR = 8'hC3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  output logic [11:0] rgb_colour,
  output logic        busy,
  output logic        err,
  output logic        ovf
);

  localparam int         NTILES  = TILES_X * TILES_Y;
  localparam logic [7:0] ROW_LIM = 8'(TILES_Y);
  localparam logic [7:0] COL_LIM = 8'(TILES_X);
  localparam logic [9:0] H_LIM   = 10'(TILES_X * 32);
  localparam logic [9:0] V_LIM   = 10'(TILES_Y * 32);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_HI,
    S_LO
`ifdef TILE_CLEAR_EN
    ,
    S_CLR_HI,
    S_CLR_LO
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [3:0]  red_q, red_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        pkt_wr;

  logic        slot_vld_q, slot_vld_d;
  logic [8:0]  slot_addr_q, slot_addr_d;
  logic [11:0] slot_data_q, slot_data_d;
  logic        commit;
  logic [8:0]  pkt_addr;

  logic [11:0] store_q [NTILES];
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [11:0] wr_data;

  logic        in_range;
  logic [8:0]  lk_addr;
  logic [11:0] rgb_d, rgb_q;

`ifdef TILE_CLEAR_EN
  localparam logic [8:0] LAST_ADDR = 9'(NTILES - 1);
  logic        pkt_clr;
  logic        sweep_act_q, sweep_act_d;
  logic [8:0]  sweep_addr_q, sweep_addr_d;
  logic [11:0] sweep_data_q, sweep_data_d;
  logic        sweep_step;
`endif

  // Tile address of the packet being completed: row*20 + col via shifts.
  assign pkt_addr = {1'b0, row_q, 4'b0000} + {3'b000, row_q, 2'b00} + {4'b0000, col_q};

  // Pending slot drains whenever the beam is blanked.
  assign commit = slot_vld_q & ~video_on;

  // Packet parser: next state, field latches and error pulse.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    red_d   = red_q;
    err_d   = 1'b0;
    pkt_wr  = 1'b0;
`ifdef TILE_CLEAR_EN
    pkt_clr = 1'b0;
`endif
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == HDR_WR) begin
            state_d = S_ROW;
`ifdef TILE_CLEAR_EN
          end else if (rx_data == HDR_CLR) begin
            // A second fill request cannot queue behind a running sweep.
            if (sweep_act_q) err_d = 1'b1;
            else             state_d = S_CLR_HI;
`else
          end else if (rx_data == HDR_CLR) begin
            // Fill-all is not built in; its header is just another stray byte.
            state_d = S_IDLE;
`endif
          end
        end
        S_ROW: begin
          if (rx_data >= ROW_LIM) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d   = rx_data[3:0];
            state_d = S_COL;
          end
        end
        S_COL: begin
          if (rx_data >= COL_LIM) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            col_d   = rx_data[4:0];
            state_d = S_HI;
          end
        end
        S_HI: begin
          if (rx_data[7:4] != 4'h0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            red_d   = rx_data[3:0];
            state_d = S_LO;
          end
        end
        S_LO: begin
          pkt_wr  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef TILE_CLEAR_EN
        S_CLR_HI: begin
          if (rx_data[7:4] != 4'h0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            red_d   = rx_data[3:0];
            state_d = S_CLR_LO;
          end
        end
        S_CLR_LO: begin
          pkt_clr = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pending slot: load on completion if free or draining now, else drop.
  always_comb begin
    slot_vld_d  = slot_vld_q & ~commit;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    ovf_d       = 1'b0;
    if (pkt_wr) begin
      if (!slot_vld_q || commit) begin
        slot_vld_d  = 1'b1;
        slot_addr_d = pkt_addr;
        slot_data_d = {red_q, rx_data};
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

`ifdef TILE_CLEAR_EN
  // Clear sweep: one tile per blanking cycle not used by a slot commit.
  assign sweep_step = sweep_act_q & ~video_on & ~commit;

  // Sweep counter walks 0..LAST_ADDR and stops after the final tile.
  always_comb begin
    sweep_act_d  = sweep_act_q;
    sweep_addr_d = sweep_addr_q;
    sweep_data_d = sweep_data_q;
    if (pkt_clr) begin
      sweep_act_d  = 1'b1;
      sweep_addr_d = '0;
      sweep_data_d = {red_q, rx_data};
    end else if (sweep_step) begin
      if (sweep_addr_q == LAST_ADDR) sweep_act_d  = 1'b0;
      else                           sweep_addr_d = sweep_addr_q + 9'd1;
    end
  end
`endif

  // Single store write port: slot commit has priority over the sweep.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (commit) begin
      wr_en   = 1'b1;
      wr_addr = slot_addr_q;
      wr_data = slot_data_q;
`ifdef TILE_CLEAR_EN
    end else if (sweep_step) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr_q;
      wr_data = sweep_data_q;
`endif
    end
  end

  // Pixel lookup: tile under the beam, black outside the visible area.
  always_comb begin
    in_range = video_on && (h_count < H_LIM) && (v_count < V_LIM);
    lk_addr  = '0;
    rgb_d    = '0;
    if (in_range) begin
      lk_addr = {1'b0, v_count[8:5], 4'b0000} + {3'b000, v_count[8:5], 2'b00}
              + {4'b0000, h_count[9:5]};
      rgb_d   = store_q[lk_addr];
    end
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Parser fields, status pulses, pending slot, sweep and output colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      red_q        <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      slot_vld_q   <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      rgb_q        <= '0;
`ifdef TILE_CLEAR_EN
      sweep_act_q  <= 1'b0;
      sweep_addr_q <= '0;
      sweep_data_q <= '0;
`endif
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      red_q        <= red_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      slot_vld_q   <= slot_vld_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      rgb_q        <= rgb_d;
`ifdef TILE_CLEAR_EN
      sweep_act_q  <= sweep_act_d;
      sweep_addr_q <= sweep_addr_d;
      sweep_data_q <= sweep_data_d;
`endif
    end
  end

  // Tile store: cleared by reset, at most one write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTILES; i++) store_q[i] <= '0;
    end else if (wr_en) begin
      store_q[wr_addr] <= wr_data;
    end
  end

  assign rgb_colour = rgb_q;
  assign err        = err_q;
  assign ovf        = ovf_q;
`ifdef TILE_CLEAR_EN
  assign busy = (state_q != S_IDLE) | slot_vld_q | sweep_act_q;
`else
  assign busy = (state_q != S_IDLE) | slot_vld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_update_ctrl
// Purpose  : Directed bench for tile_update_ctrl. Stimulus pushes expected
//            responses (tagged with the cycle they are due) into a scoreboard;
//            a negedge monitor pops and compares them, and flags any err/ovf
//            pulse that nothing expected.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_update_ctrl;

  localparam int K_RGB  = 0;
  localparam int K_BUSY = 1;
  localparam int K_ERR  = 2;
  localparam int K_OVF  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
    string       name;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        video_on;
  logic [11:0] rgb_colour;
  logic        busy;
  logic        err;
  logic        ovf;

  ev_t sb[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  tile_update_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .h_count    (h_count),
    .v_count    (v_count),
    .video_on   (video_on),
    .rgb_colour (rgb_colour),
    .busy       (busy),
    .err        (err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(input int dc, input int kind,
                                    input logic [11:0] v, input string nm);
    ev_t e;
    e.cyc  = cyc + dc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare every scoreboard entry due this cycle.
  always @(negedge clk) begin : monitor
    logic [11:0] act;
    bit          err_cov;
    bit          ovf_cov;
    err_cov = 1'b0;
    ovf_cov = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_RGB:   act = rgb_colour;
          K_BUSY:  act = {11'd0, busy};
          K_ERR:   begin act = {11'd0, err}; err_cov = 1'b1; end
          K_OVF:   begin act = {11'd0, ovf}; ovf_cov = 1'b1; end
          default: act = 12'hxxx;
        endcase
        n_checks++;
        if (act === sb[i].val) n_pass++;
        else $display("FAIL %s: got %03h expected %03h (cycle %0d)",
                      sb[i].name, act, sb[i].val, cyc);
        sb.delete(i);
      end
    end
    if (!err_cov && err !== 1'b0) begin
      n_checks++;
      $display("FAIL err_unexpected: got %b expected 0 (cycle %0d)", err, cyc);
    end
    if (!ovf_cov && ovf !== 1'b0) begin
      n_checks++;
      $display("FAIL ovf_unexpected: got %b expected 0 (cycle %0d)", ovf, cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic probe(input int h, input int v, input logic von,
                       input logic [11:0] exp, input string nm);
    h_count  = 10'(h);
    v_count  = 10'(v);
    video_on = von;
    expect_ev(1, K_RGB, exp, nm);
    @(negedge clk);
    video_on = 1'b0;
  endtask

  task automatic probe_tile(input int r, input int c, input logic [11:0] exp,
                            input string nm);
    probe(c * 32 + 5, r * 32 + 9, 1'b1, exp, nm);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    h_count  = '0;
    v_count  = '0;
    video_on = 1'b0;
    repeat (3) @(negedge clk);
    expect_ev(1, K_BUSY, 12'h000, "busy_reset");
    expect_ev(1, K_ERR,  12'h000, "err_reset");
    expect_ev(1, K_OVF,  12'h000, "ovf_reset");
    expect_ev(1, K_RGB,  12'h000, "rgb_reset");
    rst = 1'b0;
    @(negedge clk);

    // Whole map reads black after reset.
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        probe_tile(r, c, 12'h000, "reset_scan");
    expect_ev(1, K_BUSY, 12'h000, "busy_idle_after_scan");
    @(negedge clk);

    // Single write to tile (3,7) during blanking.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h07);
    send_byte(8'h0F);
    expect_ev(1, K_BUSY, 12'h001, "busy_slot_full");
    send_byte(8'h80);
    expect_ev(1, K_BUSY, 12'h000, "busy_after_commit");
    @(negedge clk);
    probe(230, 100, 1'b1, 12'hF80, "tile_3_7");
    probe(255, 127, 1'b1, 12'hF80, "tile_3_7_corner");
    probe(224, 96,  1'b1, 12'hF80, "tile_3_7_origin");
    probe(256, 100, 1'b1, 12'h000, "tile_3_8");
    probe(230, 95,  1'b1, 12'h000, "tile_2_7");
    probe(230, 100, 1'b0, 12'h000, "video_off_black");

    // Row out of range: error after byte 2, trailing bytes ignored.
    send_byte(8'hA5);
    expect_ev(1, K_ERR, 12'h001, "err_row15");
    send_byte(8'h0F);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_ev(1, K_BUSY, 12'h000, "busy_after_row_err");
    send_byte(8'h00);
    @(negedge clk);
    probe_tile(0, 0, 12'h000, "row15_no_write");
    probe_tile(3, 7, 12'hF80, "row15_store_kept");

    // Column out of range, then non-zero high nibble of R byte.
    send_byte(8'hA5);
    send_byte(8'h02);
    expect_ev(1, K_ERR, 12'h001, "err_col20");
    send_byte(8'h14);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h13);
    expect_ev(1, K_ERR, 12'h001, "err_hi_nibble");
    expect_ev(1, K_BUSY, 12'h000, "busy_after_hi_err");
    send_byte(8'h10);
    @(negedge clk);
    probe_tile(2, 19, 12'h000, "bad_pkts_no_write");

    // Stray byte in IDLE is ignored.
    expect_ev(1, K_BUSY, 12'h000, "busy_stray_byte");
    send_byte(8'h5A);

    // Last tile (14,19) and the visible-area edges.
    send_byte(8'hA5);
    send_byte(8'h0E);
    send_byte(8'h13);
    send_byte(8'h0A);
    send_byte(8'hBC);
    @(negedge clk);
    probe(639, 479, 1'b1, 12'hABC, "tile_14_19_corner");
    probe(640, 479, 1'b1, 12'h000, "h_out_of_range");
    probe(639, 480, 1'b1, 12'h000, "v_out_of_range");

    // Slot full during active video: second packet overflows.
    video_on = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    expect_ev(1, K_OVF, 12'h001, "ovf_second_pkt");
    send_byte(8'h56);
    expect_ev(1, K_BUSY, 12'h001, "busy_slot_waiting");
    @(negedge clk);
    video_on = 1'b0;
    @(negedge clk);
    probe_tile(1, 1, 12'h123, "first_pkt_committed");
    probe_tile(1, 2, 12'h000, "dropped_pkt_absent");

    // Slot draining in the same cycle a new packet completes: no drop.
    video_on = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h04);
    send_byte(8'h04);
    send_byte(8'h44);
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h05);
    send_byte(8'h05);
    video_on = 1'b0;
    send_byte(8'h55);
    @(negedge clk);
    probe_tile(4, 4, 12'h444, "held_pkt_committed");
    probe_tile(5, 5, 12'h555, "same_cycle_load");

    // Reset mid-packet, with a header arriving alongside reset.
    send_byte(8'hA5);
    send_byte(8'h02);
    rst      = 1'b1;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    expect_ev(1, K_BUSY, 12'h000, "busy_after_rst");
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    send_byte(8'h05);
    send_byte(8'h00);
    expect_ev(1, K_BUSY, 12'h000, "busy_ignored_after_rst");
    send_byte(8'h0F);
    @(negedge clk);
    probe_tile(2, 5, 12'h000, "no_write_after_rst");
    probe_tile(3, 7, 12'h000, "rst_clears_store");
    probe_tile(14, 19, 12'h000, "rst_clears_last");

`ifdef TILE_CLEAR_EN
    // Fill-all: 300-cycle sweep, second clear header rejected meanwhile.
    send_byte(8'hC3);
    send_byte(8'h00);
    expect_ev(1,   K_BUSY, 12'h001, "busy_sweep_start");
    expect_ev(300, K_BUSY, 12'h001, "busy_sweep_last");
    expect_ev(301, K_BUSY, 12'h000, "busy_sweep_done");
    send_byte(8'h0F);
    expect_ev(1, K_ERR, 12'h001, "err_clr_during_sweep");
    send_byte(8'hC3);
    repeat (305) @(negedge clk);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        probe_tile(r, c, 12'h00F, "cleared_scan");
`else
    // Without the fill option the clear header is an ordinary stray byte.
    send_byte(8'hC3);
    send_byte(8'h00);
    expect_ev(1, K_BUSY, 12'h000, "busy_clr_ignored");
    send_byte(8'h0F);
    repeat (2) @(negedge clk);
    probe_tile(0, 0, 12'h000, "clr_no_effect");
`endif

    repeat (3) @(negedge clk);
    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s: got never-checked expected due at cycle %0d",
               sb[i].name, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
